key_fetch_checker: RTL and testbench

Read-only initiator on the single-port word memory interface (address / we / wd / data_out): on request, fetches a contiguous block of words starting at the protected key slot, returns the key word and an XOR checksum of the block, and flags tampering when the key slot no longer holds the provisioned key. It sits beside the key-storage memory, at the other end of its bus. It is the security check that detects a mutable write having overwritten the key slot since reset.

---
 rtl/key_store_pkg.sv | 17 +
 rtl/key_fetch_checker_if.sv | 13 +
 rtl/key_fetch_addr_gen.sv | 31 +++
 rtl/key_fetch_checker.sv | 98 +++++++++
 tb/tb_key_fetch_checker.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_store_pkg.sv
// Shared constants and types for the key-storage memory and its fetch/check initiator.
// Both ends import the default key slot and key value so they cannot drift apart.
package key_store_pkg;
  localparam int KEY_WORD_W = 32;
  localparam int ADDR_W     = 32;

  localparam logic [ADDR_W-1:0]     DEF_KEY_ADDR     = 32'h0000_0000;
  localparam int                    DEF_NUM_WORDS    = 4;
  localparam logic [KEY_WORD_W-1:0] DEF_EXPECTED_KEY = 32'h1035_9987;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } kf_state_e;
endpackage

// File: rtl/key_fetch_checker_if.sv
// Single-port word memory bus: initiator drives address/we/wd, memory returns data_out
// one cycle after the address is presented.
interface key_fetch_checker_if;
  import key_store_pkg::*;

  logic [ADDR_W-1:0]     address;
  logic                  we;
  logic [KEY_WORD_W-1:0] wd;
  logic [KEY_WORD_W-1:0] rdata;

  modport master (output address, we, wd, input rdata);
  modport slave  (input address, we, wd, output rdata);
endinterface

// File: rtl/key_fetch_addr_gen.sv
// Issue counter and registered read address for the key block walk.
// 'last' is high while the final address of the block is on the bus.
module key_fetch_addr_gen
  import key_store_pkg::*;
#(
  parameter logic [ADDR_W-1:0] KEY_ADDR  = DEF_KEY_ADDR,
  parameter int                NUM_WORDS = DEF_NUM_WORDS,
  localparam int               CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  output logic [ADDR_W-1:0] address,
  output logic              last
);
  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(NUM_WORDS - 1));

  // Address holds on the final word; wrap past the top of memory is plain modulo arithmetic.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt     <= '0;
      address <= KEY_ADDR;
    end else if (adv && !last) begin
      cnt     <= cnt + CNT_W'(1);
      address <= address + ADDR_W'(4);
    end
  end
endmodule

// File: rtl/key_fetch_checker.sv
// Reads NUM_WORDS words from the key slot, returns the key word and XOR checksum,
// and latches a sticky tamper flag whenever the key slot no longer holds the provisioned key.
module key_fetch_checker
  import key_store_pkg::*;
#(
  parameter logic [ADDR_W-1:0]     KEY_ADDR     = DEF_KEY_ADDR,
  parameter int                    NUM_WORDS    = DEF_NUM_WORDS,
  parameter logic [KEY_WORD_W-1:0] EXPECTED_KEY = DEF_EXPECTED_KEY,
  localparam int                   CNT_W        = $clog2(NUM_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [KEY_WORD_W-1:0] key_out,
  output logic [KEY_WORD_W-1:0] checksum,
  output logic                  key_ok,
  output logic                  tamper,
  key_fetch_checker_if.master   mem
);
  kf_state_e             state, state_nx;
  logic                  load, adv, issue_last, final_cap;
  logic                  vld_pipe;
  logic [CNT_W-1:0]      cap_cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [KEY_WORD_W-1:0] key_nx;

  assign load = (state == S_IDLE) && start;
  assign adv  = (state == S_ISSUE);

  key_fetch_addr_gen #(
    .KEY_ADDR  (KEY_ADDR),
    .NUM_WORDS (NUM_WORDS)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .adv     (adv),
    .address (addr_q),
    .last    (issue_last)
  );

  assign mem.address = addr_q;
  assign mem.we      = 1'b0;
  assign mem.wd      = '0;

  assign final_cap = vld_pipe && (cap_cnt == CNT_W'(NUM_WORDS - 1));
  // Key value as it will stand after this edge; lets key_ok land together with done.
  assign key_nx    = (vld_pipe && cap_cnt == '0) ? mem.rdata : key_out;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)      state_nx = S_ISSUE;
      S_ISSUE: if (issue_last) state_nx = S_DRAIN;
      S_DRAIN: if (final_cap)  state_nx = S_DONE;
      S_DONE:                  state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ISSUE) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Capture pipe: a word on the bus this cycle is valid on mem.rdata the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= 1'b0;
      cap_cnt  <= '0;
      key_out  <= '0;
      checksum <= '0;
      key_ok   <= 1'b0;
      tamper   <= 1'b0;
    end else begin
      vld_pipe <= adv;
      if (load) begin
        cap_cnt  <= '0;
        checksum <= '0;
      end else if (vld_pipe) begin
        cap_cnt  <= cap_cnt + CNT_W'(1);
        checksum <= checksum ^ mem.rdata;
        key_out  <= key_nx;
      end
      if (final_cap) begin
        key_ok <= (key_nx == EXPECTED_KEY);
        tamper <= tamper | (key_nx != EXPECTED_KEY);
      end
    end
  end
endmodule

// File: tb/tb_key_fetch_checker.sv
// Directed bench for key_fetch_checker: cycle-level reference model plus literal spot checks.
module tb_key_fetch_checker;
  import key_store_pkg::*;

  localparam int          N  = 4;
  localparam logic [31:0] KA = 32'h0000_0000;
  localparam logic [31:0] EK = 32'h1035_9987;
  localparam int          NB = 1;
  localparam logic [31:0] KB = 32'h0000_0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_b = 1'b0;
  logic busy, done, key_ok, tamper;
  logic busy_b, done_b, key_ok_b, tamper_b;
  logic [31:0] key_out, checksum, key_out_b, checksum_b;
  logic [31:0] mem [64];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_fetch_checker_if bus_a ();
  key_fetch_checker_if bus_b ();

  always @(posedge clk) bus_a.rdata <= mem[bus_a.address[7:2]];
  always @(posedge clk) bus_b.rdata <= mem[bus_b.address[7:2]];

  key_fetch_checker #(.KEY_ADDR(KA), .NUM_WORDS(N), .EXPECTED_KEY(EK)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .key_out(key_out), .checksum(checksum), .key_ok(key_ok), .tamper(tamper), .mem(bus_a));

  key_fetch_checker #(.KEY_ADDR(KB), .NUM_WORDS(NB), .EXPECTED_KEY(EK)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .key_out(key_out_b), .checksum(checksum_b), .key_ok(key_ok_b), .tamper(tamper_b), .mem(bus_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a check accepted in cycle t0 is busy t0+1..t0+N+1 and done at t0+N+2.
  int   cyc = 0, t0 = 0;
  bit   mvalid = 0, active = 0, rst_addr = 0;
  logic [31:0] r_key = '0, r_sum = '0, p_key = '0, p_sum = '0;
  bit   r_ok = 0, r_tamp = 0, p_ok = 0;

  always @(negedge clk) begin
    int  k;
    bit  acc;
    k = cyc - t0;
    chk("we_a", 32'(bus_a.we), 32'd0);
    chk("wd_a", bus_a.wd, 32'd0);
    chk("we_b", 32'(bus_b.we), 32'd0);
    chk("wd_b", bus_b.wd, 32'd0);
    if (mvalid) begin
      if (active && k == N + 2) begin
        r_key  = p_key;
        r_sum  = p_sum;
        r_ok   = p_ok;
        r_tamp = r_tamp | !p_ok;
      end
      chk("m_busy", 32'(busy), 32'(active && k >= 1 && k <= N + 1));
      chk("m_done", 32'(done), 32'(active && k == N + 2));
      if (active && k >= 1 && k <= N) chk("m_addr", bus_a.address, KA + 32'(4 * (k - 1)));
      else if (rst_addr)              chk("m_addr_rst", bus_a.address, KA);
      chk("m_tamper", 32'(tamper), 32'(r_tamp));
      if (!(active && k <= N + 1)) begin
        chk("m_key", key_out, r_key);
        chk("m_sum", checksum, r_sum);
        chk("m_ok", 32'(key_ok), 32'(r_ok));
      end
    end
    if (reset) begin
      mvalid = 1; active = 0; rst_addr = 1;
      r_key = '0; r_sum = '0; r_ok = 0; r_tamp = 0;
    end else if (mvalid) begin
      acc = start && !active;
      if (active && k >= N + 2) active = 0;
      if (acc) begin
        active = 1; t0 = cyc; rst_addr = 0;
        p_key = mem[KA / 4];
        p_sum = '0;
        for (int i = 0; i < N; i++) p_sum ^= mem[KA / 4 + i];
        p_ok = (p_key == EK);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, return cycles until done (start cycle = 0); bounded.
  task automatic run_a(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, dn, d0, d1, seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h1035_9987;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem[3] = 32'h0000_0004;
    mem[4] = 32'hA5A5_0001;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tamper", 32'(tamper), 32'd0);
    chk("rst_key", key_out, 32'd0);
    chk("rst_addr", bus_a.address, 32'h0);
    chk("rst_addr_b", bus_b.address, 32'h10);
    tick();

    // Basic check: XOR of the four words is 0x2306_AAB0
    run_a(n);
    chk("lat_basic", 32'(n), 32'd6);
    chk("key_basic", key_out, 32'h1035_9987);
    chk("sum_basic", checksum, 32'h2306_AAB0);
    chk("ok_basic", 32'(key_ok), 32'd1);
    chk("tamp_basic", 32'(tamper), 32'd0);
    tick();

    // Key slot overwritten, then restored: tamper stays set
    mem[0] = 32'hDEAD_BEEF;
    run_a(n);
    chk("lat_tamp", 32'(n), 32'd6);
    chk("key_tamp", key_out, 32'hDEAD_BEEF);
    chk("ok_tamp", 32'(key_ok), 32'd0);
    chk("tamp_set", 32'(tamper), 32'd1);
    tick();
    mem[0] = EK;
    run_a(n);
    chk("ok_restored", 32'(key_ok), 32'd1);
    chk("tamp_sticky", 32'(tamper), 32'd1);
    tick();

    // start held for 12 cycles
    dn = 0; d0 = -1; d1 = -1;
    for (int c = 0; c < 24; c++) begin
      start = (c < 12);
      if (done) begin
        if (dn == 0) d0 = c;
        else if (dn == 1) d1 = c;
        dn++;
      end
      tick();
    end
    start = 1'b0;
    chk("burst_cnt", 32'(dn), 32'd2);
    chk("burst_first", 32'(d0), 32'd6);
    chk("burst_gap", 32'(d1 - d0), 32'd7);

    // Reset two cycles into a check
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_tamper", 32'(tamper), 32'd0);
    chk("abort_key", key_out, 32'd0);
    chk("abort_sum", checksum, 32'd0);
    chk("abort_ok", 32'(key_ok), 32'd0);
    chk("abort_addr", bus_a.address, KA);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_a(n);
    chk("lat_after", 32'(n), 32'd6);
    chk("sum_after", checksum, 32'h2306_AAB0);
    chk("ok_after", 32'(key_ok), 32'd1);
    tick();

    // Single-word check at key slot 0x10
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_addr", bus_b.address, 32'h10);
    chk("b_busy", 32'(busy_b), 32'd1);
    n = 1;
    while (!done_b && n < 20) begin
      tick();
      n++;
    end
    chk("b_lat", 32'(n), 32'd3);
    chk("b_key", key_out_b, 32'hA5A5_0001);
    chk("b_sum", checksum_b, 32'hA5A5_0001);
    chk("b_ok", 32'(key_ok_b), 32'd0);
    chk("b_tamper", 32'(tamper_b), 32'd1);
    tick();
    chk("b_done_pulse", 32'(done_b), 32'd0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
